// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, optional even/odd
// parity, 1/1.5/2 stop bits) timed by the shared oversampling strobe s_tick.
// Each data, parity and stop bit is the majority of three samples taken at
// the end of its bit period.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   rx            serial line, asynchronous, idle high
//   s_tick        one-clk oversampling strobe from the baud generator
//   rx_done_tick  one-clk pulse: frame complete, dout/flags valid
//   dout          received data, LSB received first
//   parity_err    parity mismatch in last frame
//   frame_err     stop bit sampled low in last frame
//   break_det     last frame all-zero including parity and stop bits
//   busy          high whenever the receiver is not idle
module uart_rx_cfg #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            busy
);

  localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = $clog2(DBIT);

  localparam logic [SW-1:0] S_HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_VOTE0     = SW'(OVERSAMPLE - 3);
  localparam logic [SW-1:0] S_VOTE1     = SW'(OVERSAMPLE - 2);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic          PEN         = (PARITY_EN != 0);
  localparam logic          ODD         = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, RECOVER
  } state_t;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t          state, state_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic [NW-1:0]   n, n_nxt;
  logic            rx_p0, rx_p1;
  logic            rxs;
  logic            samp0, samp1;
  logic            vote;
  logic            bit_commit;
  logic            frame_end;
  logic            stop_now;
  logic [DBIT-1:0] sr;
  logic            par;
  logic            pbit;
  logic            stop_bit;

  assign rxs        = rx_p1;
  assign vote       = majority(samp0, samp1, rxs);
  assign bit_commit = s_tick && (s == S_BIT_LAST);
  // With a single stop period the stop bit is committed on the very tick that
  // ends the frame, so the fresh vote is used instead of the stored copy.
  assign stop_now   = (S_STOP_LAST == S_BIT_LAST) ? vote : stop_bit;

  // Stage p0/p1: two-flop synchroniser for the asynchronous line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      n     <= n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_HALF_LAST) begin
            // A start bit that is high again at mid-period was a glitch.
            state_nxt = rxs ? IDLE : DATA;
            s_nxt     = '0;
            n_nxt     = '0;
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_nxt = '0;
            if (n == N_LAST) state_nxt = PEN ? PARITY : STOP;
            else             n_nxt     = n + NW'(1);
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_nxt     = '0;
            state_nxt = STOP;
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP_LAST) begin
            s_nxt = '0;
            // A low stop bit may be a held break: wait for the line to idle.
            state_nxt = stop_now ? IDLE : RECOVER;
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      RECOVER: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    frame_end = (state == STOP) && s_tick && (s == S_STOP_LAST);
  end

  // Data path: vote samples, shift register, running parity, parity/stop bits
  always_ff @(posedge clk) begin
    if (s_tick && (s == S_VOTE0)) samp0 <= rxs;
    if (s_tick && (s == S_VOTE1)) samp1 <= rxs;
    if ((state == START) && s_tick && (s == S_HALF_LAST)) par <= 1'b0;
    if ((state == DATA) && bit_commit) begin
      sr  <= {vote, sr[DBIT-1:1]};
      par <= par ^ vote;
    end
    if ((state == PARITY) && bit_commit) pbit     <= vote;
    if ((state == STOP)   && bit_commit) stop_bit <= vote;
  end

  // Result registers: updated only at frame end, held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_done_tick <= frame_end;
      if (frame_end) begin
        dout       <= sr;
        parity_err <= PEN && ((par ^ pbit) != ODD);
        frame_err  <= !stop_now;
        break_det  <= (sr == '0) && (!PEN || !pbit) && !stop_now;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: one 8N1 instance (a) and one 7-bit even-parity
// instance (b). Expected frames are queued when driven; observed frames are
// queued by a monitor and matched against them.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic s_tick = 1'b0;

  logic       done_a, perr_a, ferr_a, brk_a, busy_a;
  logic [7:0] dout_a;
  logic       done_b, perr_b, ferr_b, brk_b, busy_b;
  logic [6:0] dout_b;

  int checks = 0;
  int errors = 0;

  logic [1:0]  tcnt = 2'd0;
  logic [31:0] tick_cnt = 32'd0;
  logic [31:0] t_start_a = 32'd0;
  logic [31:0] t_start_b = 32'd0;

  typedef struct packed {
    logic [8:0]  d;
    logic        pe;
    logic        fe;
    logic        bk;
    logic [31:0] t;
  } rec_t;

  rec_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];

  always #5 clk = ~clk;

  // One s_tick every 4 clocks, plus a running tick count for latency checks.
  always @(posedge clk) begin
    tcnt   <= tcnt + 2'd1;
    s_tick <= (tcnt == 2'd3);
    if (s_tick) tick_cnt <= tick_cnt + 32'd1;
  end

  uart_rx_cfg #(.DBIT(8)) u_a (
    .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick),
    .rx_done_tick(done_a), .dout(dout_a), .parity_err(perr_a),
    .frame_err(ferr_a), .break_det(brk_a), .busy(busy_a)
  );

  uart_rx_cfg #(.DBIT(7), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick),
    .rx_done_tick(done_b), .dout(dout_b), .parity_err(perr_b),
    .frame_err(ferr_b), .break_det(brk_b), .busy(busy_b)
  );

  function automatic rec_t mk(input logic [8:0] d, input logic pe, input logic fe,
                              input logic bk, input logic [31:0] t);
    rec_t r;
    r.d = d; r.pe = pe; r.fe = fe; r.bk = bk; r.t = t;
    return r;
  endfunction

  always @(negedge clk) begin
    if (done_a) obs_a.push_back(mk(9'(dout_a), perr_a, ferr_a, brk_a, tick_cnt - t_start_a));
    if (done_b) obs_b.push_back(mk(9'(dout_b), perr_b, ferr_b, brk_b, tick_cnt - t_start_b));
  end

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  // Drives one line tick by tick starting just after a tick edge; bits[i]
  // is held for 16 ticks, and tick number 'glitch' is forced low.
  task automatic send(input int which, input logic [31:0] bits, input int nticks,
                      input int glitch);
    int   idx;
    logic v;
    if (which == 0) t_start_a = tick_cnt;
    else            t_start_b = tick_cnt;
    for (int j = 1; j <= nticks; j++) begin
      idx = (j - 1) / 16;
      if (idx > 31) idx = 31;
      v = (j == glitch) ? 1'b0 : bits[idx];
      if (which == 0) rx_a = v;
      else            rx_b = v;
      wait_ticks(1);
    end
  endtask

  task automatic frame_a(input logic [7:0] data, input logic stop, input int glitch);
    exp_a.push_back(mk(9'(data), 1'b0, !stop, (data == 8'h00) && !stop, 32'd152));
    send(0, {22'h3FFFFF, stop, data, 1'b0}, 160, glitch);
    rx_a = 1'b1;
  endtask

  task automatic frame_b(input logic [6:0] data, input logic p, input logic stop);
    exp_b.push_back(mk(9'(data), (^data) ^ p, !stop,
                       (data == 7'h00) && !p && !stop, 32'd152));
    send(1, {22'h3FFFFF, stop, p, data, 1'b0}, 160, 0);
    rx_b = 1'b1;
  endtask

  task automatic check_frames(input string tag);
    rec_t o, e;
    cmp({tag, "/count_a"}, obs_a.size(), exp_a.size());
    cmp({tag, "/count_b"}, obs_b.size(), exp_b.size());
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      cmp({tag, "/a_dout"}, 32'(o.d), 32'(e.d));
      cmp({tag, "/a_perr"}, 32'(o.pe), 32'(e.pe));
      cmp({tag, "/a_ferr"}, 32'(o.fe), 32'(e.fe));
      cmp({tag, "/a_brk"},  32'(o.bk), 32'(e.bk));
      cmp({tag, "/a_ticks"}, o.t, e.t);
    end
    while (obs_b.size() > 0 && exp_b.size() > 0) begin
      o = obs_b.pop_front(); e = exp_b.pop_front();
      cmp({tag, "/b_dout"}, 32'(o.d), 32'(e.d));
      cmp({tag, "/b_perr"}, 32'(o.pe), 32'(e.pe));
      cmp({tag, "/b_ferr"}, 32'(o.fe), 32'(e.fe));
      cmp({tag, "/b_brk"},  32'(o.bk), 32'(e.bk));
      cmp({tag, "/b_ticks"}, o.t, e.t);
    end
    obs_a.delete(); exp_a.delete(); obs_b.delete(); exp_b.delete();
  endtask

  task automatic check_reset_a(input string tag);
    cmp({tag, "/done"}, 32'(done_a), 32'd0);
    cmp({tag, "/dout"}, 32'(dout_a), 32'd0);
    cmp({tag, "/perr"}, 32'(perr_a), 32'd0);
    cmp({tag, "/ferr"}, 32'(ferr_a), 32'd0);
    cmp({tag, "/brk"},  32'(brk_a),  32'd0);
    cmp({tag, "/busy"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_a("reset_a");
    cmp("reset_b/dout", 32'(dout_b), 32'd0);
    cmp("reset_b/busy", 32'(busy_b), 32'd0);
    cmp("reset_b/perr", 32'(perr_b), 32'd0);
    wait_ticks(2);

    // 8N1 byte with latency check
    frame_a(8'hA5, 1'b1, 0);
    wait_ticks(4);
    check_frames("8n1_a5");

    // 7E1: correct and wrong parity
    frame_b(7'h41, 1'b0, 1'b1);
    wait_ticks(4);
    frame_b(7'h41, 1'b1, 1'b1);
    wait_ticks(4);
    check_frames("7e1_41");

    // Single-tick glitch at s=OVERSAMPLE-2 of data bit 1
    frame_a(8'hFF, 1'b1, 39);
    wait_ticks(4);
    check_frames("glitch_ff");

    // False start: low for 5 ticks only
    send(0, 32'hFFFFFFFE, 5, 0);
    cmp("false_start/busy_mid", 32'(busy_a), 32'd1);
    rx_a = 1'b1;
    wait_ticks(8);
    cmp("false_start/busy_end", 32'(busy_a), 32'd0);
    cmp("false_start/dout", 32'(dout_a), 32'hFF);
    check_frames("false_start");

    // Framing error (stop bit low, data non-zero)
    frame_a(8'h5A, 1'b0, 0);
    wait_ticks(4);
    cmp("ferr/busy", 32'(busy_a), 32'd0);
    check_frames("ferr_5a");

    // Break: line low for three frame times
    exp_a.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1, 32'd152));
    send(0, 32'h00000000, 480, 0);
    cmp("break/busy_held", 32'(busy_a), 32'd1);
    rx_a = 1'b1;
    wait_ticks(4);
    cmp("break/busy_released", 32'(busy_a), 32'd0);
    check_frames("break");

    // Reset in the middle of the data bits, then a clean frame
    send(0, {22'h3FFFFF, 1'b1, 8'h3C, 1'b0}, 50, 0);
    cmp("abort/busy_mid", 32'(busy_a), 32'd1);
    reset = 1'b1;
    rx_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_a("abort_reset");
    wait_ticks(1);
    frame_a(8'h3C, 1'b1, 0);
    wait_ticks(4);
    check_frames("after_abort_3c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
